// File: rtl/r0_mux_pkg.sv
// r0_mux_pkg: shared width, FSM states and command codes for the R0 operand router
package r0_mux_pkg;
   localparam int WIDTH = 8;
   typedef enum logic [2:0] {IDLE, EXEC1, EXEC2, EXEC3, DONE} state_t;
   localparam logic [1:0] CMD_PASS  = 2'd0;
   localparam logic [1:0] CMD_LOAD  = 2'd1;
   localparam logic [1:0] CMD_SWAP  = 2'd2;
   localparam logic [1:0] CMD_ROUTE = 2'd3;
endpackage

// File: rtl/r0_mux_if.sv
// r0_mux_if: command strobe, operands and operand buses of the R0 router
interface r0_mux_if #(parameter int WIDTH = r0_mux_pkg::WIDTH);
   logic             en;
   logic [1:0]       state;
   logic [WIDTH-1:0] value1;
   logic [WIDTH-1:0] value2;
   logic [WIDTH-1:0] Output1;
   logic [WIDTH-1:0] Output2;
   logic             ready;
   modport master (output en, state, value1, value2, input Output1, Output2, ready);
   modport slave  (input en, state, value1, value2, output Output1, Output2, ready);
endinterface

// File: rtl/r0_mux.sv
// r0_mux: routes latched operands onto two buses via scratch register R0;
// command 2 swaps through R0 over three cycles, ready pulses once per command.
module r0_mux
   import r0_mux_pkg::*;
#(
   parameter int WIDTH = r0_mux_pkg::WIDTH
) (
   input logic    clk,
   input logic    rst,
   r0_mux_if.slave bus
);
   state_t cur, nxt;
   logic [1:0] cmd_q;
   logic [WIDTH-1:0] v1_q, v2_q, r0, r0_d, o1_d, o2_d;
   always_comb begin
      nxt = cur;
      r0_d = r0;
      o1_d = bus.Output1;
      o2_d = bus.Output2;
      case (cur)
         IDLE: nxt = bus.en ? EXEC1 : IDLE;
         EXEC1: begin
            nxt = cmd_q == CMD_SWAP ? EXEC2 : DONE;
            r0_d = (cmd_q == CMD_LOAD || cmd_q == CMD_SWAP) ? v1_q : r0;
            o1_d = cmd_q == CMD_ROUTE ? r0 : cmd_q == CMD_SWAP ? bus.Output1 : v1_q;
            o2_d = cmd_q == CMD_ROUTE ? r0 : cmd_q == CMD_SWAP ? bus.Output2 : v2_q;
         end
         EXEC2: begin
            nxt = EXEC3;
            o1_d = v2_q;
         end
         EXEC3: begin
            nxt = DONE;
            o2_d = r0;
         end
         default: nxt = IDLE;
      endcase
   end
   // ready comes straight from a flop loaded on entry to DONE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur <= IDLE;
         cmd_q <= '0;
         v1_q <= '0;
         v2_q <= '0;
         r0 <= '0;
         bus.Output1 <= '0;
         bus.Output2 <= '0;
         bus.ready <= 1'b0;
      end else begin
         cur <= nxt;
         r0 <= r0_d;
         bus.Output1 <= o1_d;
         bus.Output2 <= o2_d;
         bus.ready <= nxt == DONE;
         if (cur == IDLE && bus.en) begin
            cmd_q <= bus.state;
            v1_q <= bus.value1;
            v2_q <= bus.value2;
         end
      end
   end
endmodule

// File: tb/tb_r0_mux.sv
// tb_r0_mux: scenario tasks with a result scoreboard popped on each ready pulse
module tb_r0_mux;
   typedef struct packed {
      logic [7:0] o1;
      logic [7:0] o2;
   } exp_t;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int errors = 0;
   int checks = 0;
   exp_t q[$];
   logic [7:0] m_r0 = 8'h00;
   bit prev_ready = 1'b0;
   r0_mux_if #(.WIDTH(8)) bus ();
   r0_mux #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   // scoreboard: every ready pulse must match the oldest pending expectation
   always @(negedge clk) begin
      if (!rst && bus.ready) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: got ready=1 with O1=%h O2=%h, required no pulse", bus.Output1, bus.Output2);
         end else begin
            exp_t e;
            e = q.pop_front();
            if ({bus.Output1, bus.Output2} !== {e.o1, e.o2}) begin
               errors++;
               $display("FAIL result: got O1=%h O2=%h, required O1=%h O2=%h", bus.Output1, bus.Output2, e.o1, e.o2);
            end
         end
         checks++;
         if (prev_ready) begin
            errors++;
            $display("FAIL ready_width: got ready high two cycles in a row, required one-cycle pulse");
         end
      end
      prev_ready = !rst && bus.ready;
   end
   task automatic push_exp(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      case (c)
         2'd0: e = '{o1: a, o2: b};
         2'd1: begin e = '{o1: a, o2: b}; m_r0 = a; end
         2'd2: begin e = '{o1: b, o2: a}; m_r0 = a; end
         default: e = '{o1: m_r0, o2: m_r0};
      endcase
      q.push_back(e);
   endtask
   task automatic issue(input logic [1:0] c, input logic [7:0] a, input logic [7:0] b, input int lat, input bit scramble);
      int n;
      push_exp(c, a, b);
      @(negedge clk);
      bus.en = 1'b1; bus.state = c; bus.value1 = a; bus.value2 = b;
      @(posedge clk);
      #1;
      bus.en = 1'b0;
      if (scramble) begin
         bus.state = 2'd3; bus.value1 = 8'hFF; bus.value2 = 8'hFF;
      end
      n = 0;
      do begin
         @(posedge clk);
         n++;
         @(negedge clk);
      end while (!bus.ready && n < 8);
      checks++;
      if (n !== lat || bus.ready !== 1'b1) begin
         errors++;
         $display("FAIL latency_cmd%0d: got %0d edges (ready=%b), required %0d", c, n, bus.ready, lat);
      end
      @(negedge clk);
      checks++;
      if (bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL ready_fall_cmd%0d: got ready=%b, required 0", c, bus.ready);
      end
   endtask
   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({bus.Output1, bus.Output2, bus.ready} !== 17'd0) begin
         errors++;
         $display("FAIL reset_state: got O1=%h O2=%h ready=%b, required all 0", bus.Output1, bus.Output2, bus.ready);
      end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: cycle %0d got ready=%b, required 0", i, bus.ready);
         end
      end
   endtask
   task automatic test_swap();
      issue(2'd2, 8'd1, 8'd2, 3, 1'b0);
      issue(2'd3, 8'h00, 8'h00, 1, 1'b0);
   endtask
   task automatic test_load_route();
      issue(2'd1, 8'hA5, 8'h5A, 1, 1'b0);
      issue(2'd3, 8'h12, 8'h34, 1, 1'b0);
   endtask
   task automatic test_pass_busy_change();
      issue(2'd0, 8'h3C, 8'hC3, 1, 1'b1);
      issue(2'd0, 8'h80, 8'h01, 1, 1'b0);
   endtask
   task automatic test_busy_ignore_abort();
      @(negedge clk);
      bus.en = 1'b1; bus.state = 2'd2; bus.value1 = 8'h07; bus.value2 = 8'h09;
      @(posedge clk);
      @(negedge clk);
      bus.en = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.en = 1'b1; bus.state = 2'd0; bus.value1 = 8'hEE; bus.value2 = 8'hDD;
      @(posedge clk);
      @(negedge clk);
      bus.en = 1'b0;
      checks++;
      if (bus.Output1 !== 8'h09 || bus.ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_ignore: got O1=%h ready=%b, required O1=09 ready=0", bus.Output1, bus.ready);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({bus.Output1, bus.Output2, bus.ready} !== 17'd0) begin
         errors++;
         $display("FAIL abort_reset: got O1=%h O2=%h ready=%b, required all 0", bus.Output1, bus.Output2, bus.ready);
      end
      m_r0 = 8'h00;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checks++;
         if (bus.ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_ready: got ready=%b, required 0", bus.ready);
         end
      end
      issue(2'd3, 8'h44, 8'h55, 1, 1'b0);
      issue(2'd0, 8'h11, 8'h22, 1, 1'b0);
   endtask
   task automatic test_back_to_back();
      int first, last, cnt;
      first = -1; last = -1; cnt = 0;
      for (int i = 0; i < 4; i++) push_exp(2'd0, 8'h5A, 8'h6B);
      @(negedge clk);
      bus.en = 1'b1; bus.state = 2'd0; bus.value1 = 8'h5A; bus.value2 = 8'h6B;
      for (int i = 0; i < 14; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i == 9) bus.en = 1'b0;
         if (bus.ready) begin
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      checks++;
      if (cnt !== 4 || first !== 1 || last !== 10) begin
         errors++;
         $display("FAIL back_to_back: got %0d pulses at %0d..%0d, required 4 at 1..10", cnt, first, last);
      end
   endtask
   initial begin
      bus.en = 1'b0; bus.state = 2'd0; bus.value1 = 8'h00; bus.value2 = 8'h00;
      test_reset();
      test_swap();
      test_load_route();
      test_pass_busy_change();
      test_busy_ignore_abort();
      test_back_to_back();
      repeat (3) @(negedge clk);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d results pending, required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
